ifu_fetch: RTL and testbench

Instruction fetch unit: generates the sequential PC, issues requests to the instruction memory over a req/gnt/rvalid handshake, and buffers returned words in a 2-entry prefetch FIFO. It is the producer side of the IF/ID pipeline register, driving its `pc_i`, `inst_i` and `branch_slot_end_i` inputs. It also absorbs branch and flush redirects from EXU/ctrl by discarding stale responses.

---
 rtl/ifu_fetch_pkg.sv | 26 ++
 rtl/ifu_fetch_if.sv | 21 ++
 rtl/ifu_fifo.sv | 53 +++++
 rtl/ifu_fetch.sv | 125 ++++++++++++
 tb/tb_ifu_fetch.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch FIFO.
package ifu_fetch_pkg;

    localparam logic [31:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;
    localparam int          FETCH_FIFO_DEPTH  = 2;
    localparam logic [31:0] NOP_INST          = 32'h0000_0013;
    localparam logic        STOP              = 1'b1;

    typedef logic [31:0] inst_addr_t;
    typedef logic [31:0] inst_word_t;
    typedef logic [1:0]  fifo_cnt_t;

    // One prefetched instruction: its PC, the fetched word, and whether it is
    // the first instruction after a redirect.
    typedef struct packed {
        inst_addr_t pc;
        inst_word_t inst;
        logic       first;
    } fetch_entry_t;

    // Instruction addresses are always word aligned; low bits of targets are dropped.
    function automatic inst_addr_t word_align(input inst_addr_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction memory bus: req/gnt request channel plus in-order rvalid/rdata response.
interface ifu_fetch_if;
    import ifu_fetch_pkg::*;

    logic       instr_req;
    inst_addr_t instr_addr;
    logic       instr_gnt;
    logic       instr_rvalid;
    inst_word_t instr_rdata;

    modport master (
        output instr_req, instr_addr,
        input  instr_gnt, instr_rvalid, instr_rdata
    );

    modport slave (
        input  instr_req, instr_addr,
        output instr_gnt, instr_rvalid, instr_rdata
    );

endinterface

// File: rtl/ifu_fifo.sv
// Two-entry prefetch FIFO of {pc, inst, first} entries with synchronous clear.
module ifu_fifo
    import ifu_fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         n_rst_i,
    input  logic         clear,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty,
    output fifo_cnt_t    count
);

    fetch_entry_t mem [FETCH_FIFO_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == fifo_cnt_t'(FETCH_FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear drops everything in one cycle.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!n_rst_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + fifo_cnt_t'(do_push) - fifo_cnt_t'(do_pop);
        end
    end

    // Entry storage write.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is not reset; count alone decides which entries are meaningful.
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: sequential PC generation, memory request issue,
// stale-response discard after redirects, and the IF/ID producer outputs.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter inst_addr_t BOOT_ADDR = BOOT_ADDR_DEFAULT
) (
    input  logic              clk_i,
    input  logic              n_rst_i,
    input  logic [5:0]        stall_i,
    input  logic              flush_i,
    input  inst_addr_t        flush_addr_i,
    input  logic              branch_i,
    input  inst_addr_t        branch_addr_i,
    ifu_fetch_if.master       imem,
    output inst_addr_t        pc_o,
    output inst_word_t        inst_o,
    output logic              branch_slot_end_o
);

    inst_addr_t   fetch_addr;
    inst_addr_t   next_pc;
    fifo_cnt_t    outstanding;
    fifo_cnt_t    discard;
    logic         first_flag;
    logic         fetch_en;

    logic         redirect;
    inst_addr_t   redirect_addr;
    logic [2:0]   in_flight;
    logic         gnt_fire;
    logic         push_en;
    logic         pop_fire;
    logic         head_valid;
    fetch_entry_t resp_entry;
    fetch_entry_t head_entry;

    fetch_entry_t fifo_head;
    logic         fifo_full;
    logic         fifo_empty;
    fifo_cnt_t    fifo_count;
    logic         fifo_push;
    logic         fifo_pop;
    logic         unused_ok;

    // Branch wins over flush when both arrive together.
    assign redirect      = branch_i | flush_i;
    assign redirect_addr = word_align(branch_i ? branch_addr_i : flush_addr_i);

    // Never let buffered plus in-flight words exceed what the FIFO can hold.
    assign in_flight     = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem.instr_req  = fetch_en && (stall_i[0] != STOP) && !redirect
                           && (in_flight < 3'(FETCH_FIFO_DEPTH));
    assign imem.instr_addr = fetch_addr;
    assign gnt_fire        = imem.instr_req && imem.instr_gnt;

    // With no stale words pending, the oldest outstanding request sits
    // outstanding words behind fetch_addr.
    assign push_en    = imem.instr_rvalid && (discard == '0) && !redirect;
    assign resp_entry = '{pc:    fetch_addr - (inst_addr_t'(outstanding) << 2),
                          inst:  imem.instr_rdata,
                          first: first_flag};

    // An arriving word bypasses an empty FIFO so zero-wait memory sustains one word per cycle.
    assign head_valid = !fifo_empty || push_en;
    assign head_entry = fifo_empty ? resp_entry : fifo_head;
    assign pop_fire   = head_valid && (stall_i[1] != STOP) && !redirect;
    assign fifo_push  = push_en && !(fifo_empty && pop_fire);
    assign fifo_pop   = pop_fire && !fifo_empty;

    assign unused_ok  = ^{stall_i[5:2], fifo_full};

    ifu_fifo u_fifo (
        .clk_i      (clk_i),
        .n_rst_i    (n_rst_i),
        .clear      (redirect),
        .push       (fifo_push),
        .push_entry (resp_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Fetch address, in-flight/discard counters and redirect bookkeeping.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            fetch_addr  <= BOOT_ADDR;
            next_pc     <= BOOT_ADDR;
            outstanding <= '0;
            discard     <= '0;
            first_flag  <= 1'b1;
            fetch_en    <= 1'b0;
        end else begin
            fetch_en    <= 1'b1;
            outstanding <= outstanding + fifo_cnt_t'(gnt_fire) - fifo_cnt_t'(imem.instr_rvalid);
            if (redirect) begin
                fetch_addr <= redirect_addr;
                next_pc    <= redirect_addr;
                discard    <= outstanding - fifo_cnt_t'(imem.instr_rvalid);
                first_flag <= 1'b1;
            end else begin
                if (gnt_fire)                                 fetch_addr <= fetch_addr + 32'd4;
                if (imem.instr_rvalid && (discard != '0))     discard    <= discard - 2'd1;
                if (push_en)                                  first_flag <= 1'b0;
                if (pop_fire)                                 next_pc    <= head_entry.pc + 32'd4;
            end
        end
    end

    // IF/ID outputs come straight from the head entry, or a NOP bubble when nothing is buffered.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        pc_o              = next_pc;
        inst_o            = NOP_INST;
        branch_slot_end_o = 1'b0;
        if (head_valid) begin
            pc_o              = head_entry.pc;
            inst_o            = head_entry.inst;
            branch_slot_end_o = head_entry.first;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: a memory model returning each word's own
// address as data, and a reference model of the ideal instruction stream
// (sequential PCs from the last redirect target) that every delivered word is checked against.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    logic       clk_i = 1'b0;
    logic       n_rst_i;
    logic [5:0] stall_i;
    logic       flush_i;
    inst_addr_t flush_addr_i;
    logic       branch_i;
    inst_addr_t branch_addr_i;
    inst_addr_t pc_o;
    inst_word_t inst_o;
    logic       branch_slot_end_o;

    ifu_fetch_if bus ();

    ifu_fetch u_dut (
        .clk_i             (clk_i),
        .n_rst_i           (n_rst_i),
        .stall_i           (stall_i),
        .flush_i           (flush_i),
        .flush_addr_i      (flush_addr_i),
        .branch_i          (branch_i),
        .branch_addr_i     (branch_addr_i),
        .imem              (bus),
        .pc_o              (pc_o),
        .inst_o            (inst_o),
        .branch_slot_end_o (branch_slot_end_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Memory model: granted addresses awaiting their response, in order.
    inst_addr_t pend[$];
    int         gnt_pct;
    int         rv_pct;

    // Stimulus for the next cycle.
    logic [5:0] nxt_stall;
    logic       nxt_br, nxt_fl;
    inst_addr_t nxt_br_addr, nxt_fl_addr;

    // Reference stream model.
    inst_addr_t exp_pc;
    logic       exp_first;

    logic       hold_valid;
    inst_addr_t hold_addr;
    logic       delivered;
    inst_addr_t del_pc;
    int         n_delivered = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        exp_pc     = BOOT_ADDR_DEFAULT;
        exp_first  = 1'b1;
        hold_valid = 1'b0;
        nxt_br     = 1'b0;
        nxt_fl     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},  bus.instr_req, 0);
        check({tag, "_addr"}, bus.instr_addr, BOOT_ADDR_DEFAULT);
        check({tag, "_pc"},   pc_o, BOOT_ADDR_DEFAULT);
        check({tag, "_inst"}, inst_o, NOP_INST);
        check({tag, "_bse"},  branch_slot_end_o, 0);
    endtask

    // One clock cycle: drive inputs, answer the request, check outputs, advance the models.
    task automatic step();
        logic redirect;
        @(posedge clk_i);
        #1;
        stall_i       = nxt_stall;
        branch_i      = nxt_br;
        branch_addr_i = nxt_br_addr;
        flush_i       = nxt_fl;
        flush_addr_i  = nxt_fl_addr;
        nxt_br        = 1'b0;
        nxt_fl        = 1'b0;
        bus.instr_rvalid = (pend.size() > 0) && ($urandom_range(99) < rv_pct);
        bus.instr_rdata  = bus.instr_rvalid ? pend[0] : 32'h0;
        #1;
        bus.instr_gnt = bus.instr_req && ($urandom_range(99) < gnt_pct);
        #1;
        redirect = branch_i || flush_i;
        if (redirect) check("req_during_redirect", bus.instr_req, 0);
        if (bus.instr_req) begin
            check("addr_aligned", bus.instr_addr[1:0], 0);
            if (hold_valid) check("addr_hold", bus.instr_addr, hold_addr);
        end
        hold_valid = bus.instr_req && !bus.instr_gnt;
        hold_addr  = bus.instr_addr;

        delivered = (inst_o != NOP_INST) && !stall_i[1] && !redirect;
        if (inst_o == NOP_INST) check("nop_slot_end", branch_slot_end_o, 0);
        if (delivered) begin
            check("stream_pc",   pc_o, exp_pc);
            check("stream_inst", inst_o, exp_pc);
            check("stream_bse",  branch_slot_end_o, exp_first);
            del_pc    = pc_o;
            n_delivered++;
            exp_pc    = exp_pc + 32'd4;
            exp_first = 1'b0;
        end
        if (branch_i) begin
            exp_pc    = branch_addr_i & ~32'd3;
            exp_first = 1'b1;
        end else if (flush_i) begin
            exp_pc    = flush_addr_i & ~32'd3;
            exp_first = 1'b1;
        end

        if (bus.instr_rvalid) void'(pend.pop_front());
        if (bus.instr_req && bus.instr_gnt) pend.push_back(bus.instr_addr);
        check("outstanding_max", pend.size() <= 2, 1);
    endtask

    // Run until a word is delivered (bounded) and check its PC.
    task automatic expect_next_pc(input string tag, input inst_addr_t pc);
        logic seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            seen = delivered;
        end
        check({tag, "_seen"}, seen, 1);
        if (seen) check(tag, del_pc, pc);
    endtask

    initial begin
        n_rst_i          = 1'b0;
        stall_i          = '0;
        flush_i          = 1'b0;
        flush_addr_i     = '0;
        branch_i         = 1'b0;
        branch_addr_i    = '0;
        bus.instr_gnt    = 1'b0;
        bus.instr_rvalid = 1'b0;
        bus.instr_rdata  = '0;
        nxt_stall        = '0;
        nxt_br_addr      = '0;
        nxt_fl_addr      = '0;
        gnt_pct          = 100;
        rv_pct           = 100;
        model_reset();
        #1;
        check_reset_outputs("reset");
        #20 n_rst_i = 1'b1;

        // Zero-wait memory from boot: 0x0, 0x4, 0x8 with the first flagged.
        expect_next_pc("boot_pc0", 32'h0);
        expect_next_pc("boot_pc4", 32'h4);
        expect_next_pc("boot_pc8", 32'h8);

        // Hold off IF/ID: FIFO fills and requests stop; release loses nothing.
        nxt_stall = 6'b000010;
        repeat (5) step();
        check("stall_full_req", bus.instr_req, 0);
        nxt_stall = '0;
        repeat (6) step();

        // Redirect timing with zero-wait memory: first target word at N+2, then 1/cycle.
        nxt_br = 1'b1; nxt_br_addr = 32'h0000_0080;
        step();
        step();
        check("redir_n1_bubble", delivered, 0);
        step();
        check("redir_n2_deliver", delivered, 1);
        check("redir_n2_pc", del_pc, 32'h0000_0080);
        for (int i = 0; i < 3; i++) begin
            step();
            check("redir_sustain", delivered, 1);
        end

        // Branch with two responses outstanding: both stale words dropped.
        rv_pct = 0;
        repeat (3) step();
        check("two_outstanding", pend.size(), 2);
        nxt_br = 1'b1; nxt_br_addr = 32'h0000_0100;
        step();
        rv_pct = 100;
        expect_next_pc("branch_target_pc", 32'h0000_0100);

        // Branch beats flush in the same cycle.
        nxt_br = 1'b1; nxt_br_addr = 32'h0000_0200;
        nxt_fl = 1'b1; nxt_fl_addr = 32'h0000_0300;
        step();
        expect_next_pc("branch_over_flush", 32'h0000_0200);

        // Misaligned flush target is word aligned.
        nxt_fl = 1'b1; nxt_fl_addr = 32'h0000_0303;
        step();
        expect_next_pc("misaligned_flush", 32'h0000_0300);

        // Grant withheld for 3 cycles: address holds (checked every cycle).
        gnt_pct = 0;
        repeat (3) step();
        gnt_pct = 100;
        repeat (4) step();

        // Fetch address wraps past the top of the address space.
        nxt_br = 1'b1; nxt_br_addr = 32'hFFFF_FFF8;
        step();
        expect_next_pc("wrap_fff8", 32'hFFFF_FFF8);
        expect_next_pc("wrap_fffc", 32'hFFFF_FFFC);
        expect_next_pc("wrap_zero", 32'h0000_0000);

        // Randomized traffic: variable memory latency, stalls and redirects.
        for (int i = 0; i < 1500; i++) begin
            gnt_pct   = $urandom_range(100, 20);
            rv_pct    = $urandom_range(100, 30);
            nxt_stall = {4'b0, ($urandom_range(99) < 20), ($urandom_range(99) < 15)};
            if ($urandom_range(99) < 4) begin
                nxt_br = 1'b1; nxt_br_addr = $urandom;
            end
            if ($urandom_range(99) < 3) begin
                nxt_fl = 1'b1; nxt_fl_addr = $urandom;
            end
            step();
        end
        gnt_pct = 100; rv_pct = 100; nxt_stall = '0;
        repeat (4) step();

        // Asynchronous reset in the middle of a burst.
        #1;
        n_rst_i          = 1'b0;
        bus.instr_gnt    = 1'b0;
        bus.instr_rvalid = 1'b0;
        stall_i          = '0;
        branch_i         = 1'b0;
        flush_i          = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(posedge clk_i);
        @(posedge clk_i);
        #3 n_rst_i = 1'b1;
        expect_next_pc("restart_pc0", 32'h0);
        expect_next_pc("restart_pc4", 32'h4);

        check("progress", n_delivered > 200, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
